delay_apply_ctrl: RTL and testbench

Sequences software delay updates into the F-engine coarse-delay datapath. The block takes the 32-bit control word written by the PowerPC through its OPB software register, which is already retimed to `user_clk`. On an arm request it latches and clamps the requested delay, then waits for the next system sync, or applies immediately if requested. It issues a one-cycle load strobe to the delay buffer, holds off further requests while the buffer settles, and reports status back to software through a readback register.

---
 rtl/delay_apply_ctrl_if.sv | 35 +++
 rtl/delay_apply_ctrl.sv | 151 +++++++++++++++
 tb/tb_delay_apply_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/delay_apply_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : delay_apply_ctrl_if
// Description : Software control / delay datapath bundle for delay_apply_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface delay_apply_ctrl_if #(
    parameter int DELAY_W = 11
);
    logic [31:0]        ctrl_word;
    logic               sync_in;
    logic [DELAY_W-1:0] delay_out;
    logic               delay_load;
    logic               busy;
    logic [31:0]        status_word;

    modport master (
        output ctrl_word,
        output sync_in,
        input  delay_out,
        input  delay_load,
        input  busy,
        input  status_word
    );

    modport slave (
        input  ctrl_word,
        input  sync_in,
        output delay_out,
        output delay_load,
        output busy,
        output status_word
    );
endinterface
`default_nettype wire

// File: rtl/delay_apply_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : delay_apply_ctrl
// Description : Arms, clamps and sync-aligns software delay updates into the
//               coarse-delay buffer, with settle hold-off and status readback.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_apply_ctrl #(
    parameter int DELAY_W    = 11,
    parameter int MAX_DELAY  = 2047,
    parameter int SETTLE_CYC = 16
) (
    input  wire logic          user_clk,
    input  wire logic          user_rst_n,
    delay_apply_ctrl_if.slave  bus
);

    localparam int                 c_cnt_w       = $clog2(SETTLE_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYC - 1);
    localparam logic [DELAY_W-1:0] c_max_req     = DELAY_W'(MAX_DELAY);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_SYNC = 2'd1,
        S_LOAD      = 2'd2,
        S_SETTLE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        ctrl_q, ctrl_d;
    logic               arm_prev_q, arm_prev_d;
    logic               clr_prev_q, clr_prev_d;
    logic [DELAY_W-1:0] req_q, req_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [DELAY_W-1:0] delay_out_q, delay_out_d;
    logic               delay_load_q, delay_load_d;
    logic [7:0]         apply_cnt_q, apply_cnt_d;
    logic               clamped_q, clamped_d;
    logic               overrun_q, overrun_d;
    logic [31:0]        status_q, status_d;

    logic               w_arm_edge;
    logic               w_clr_edge;
    logic               w_req_over;
    logic [DELAY_W-1:0] w_req_clamped;
    logic               ctrl_unused;

    assign w_arm_edge    = ctrl_q[31] & ~arm_prev_q;
    assign w_clr_edge    = ctrl_q[29] & ~clr_prev_q;
    assign w_req_over    = ctrl_q[DELAY_W-1:0] > c_max_req;
    assign w_req_clamped = w_req_over ? c_max_req : ctrl_q[DELAY_W-1:0];
    assign ctrl_unused   = &{1'b0, ctrl_q[28:DELAY_W]};

    always_comb begin
        ctrl_d       = bus.ctrl_word;
        arm_prev_d   = ctrl_q[31];
        clr_prev_d   = ctrl_q[29];
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        delay_out_d  = delay_out_q;
        delay_load_d = 1'b0;
        apply_cnt_d  = apply_cnt_q;
        clamped_d    = clamped_q;
        overrun_d    = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (w_arm_edge) begin
                    req_d = w_req_clamped;
                    if (w_req_over) clamped_d = 1'b1;
                    if (ctrl_q[30]) begin
                        state_d      = S_LOAD;
                        delay_out_d  = w_req_clamped;
                        delay_load_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_SYNC;
                    end
                end
            end
            S_WAIT_SYNC: begin
                if (bus.sync_in) begin
                    state_d      = S_LOAD;
                    delay_out_d  = req_q;
                    delay_load_d = 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
                cnt_d   = c_settle_last;
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    apply_cnt_d = apply_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase

        // A second arm while busy is dropped, only flagged.
        if (w_arm_edge && (state_q != S_IDLE)) overrun_d = 1'b1;

        // Clear takes priority over any same-cycle increment or flag set.
        if (w_clr_edge) begin
            apply_cnt_d = 8'd0;
            clamped_d   = 1'b0;
            overrun_d   = 1'b0;
        end

        status_d = {19'd0, 1'b0, state_q, overrun_q, clamped_q, apply_cnt_q};
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            ctrl_q       <= 32'hA000_0000;
            arm_prev_q   <= 1'b1;
            clr_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            delay_out_q  <= '0;
            delay_load_q <= 1'b0;
            apply_cnt_q  <= 8'd0;
            clamped_q    <= 1'b0;
            overrun_q    <= 1'b0;
            status_q     <= 32'd0;
        end else begin
            ctrl_q       <= ctrl_d;
            arm_prev_q   <= arm_prev_d;
            clr_prev_q   <= clr_prev_d;
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            delay_out_q  <= delay_out_d;
            delay_load_q <= delay_load_d;
            apply_cnt_q  <= apply_cnt_d;
            clamped_q    <= clamped_d;
            overrun_q    <= overrun_d;
            status_q     <= status_d;
        end
    end

    assign bus.delay_out   = delay_out_q;
    assign bus.delay_load  = delay_load_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.status_word = status_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_apply_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_apply_ctrl
// Description : Directed self-checking bench for delay_apply_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_apply_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   loads;

    delay_apply_ctrl_if #(.DELAY_W(12)) bus ();

    delay_apply_ctrl #(
        .DELAY_W    (12),
        .MAX_DELAY  (2047),
        .SETTLE_CYC (16)
    ) dut (
        .user_clk   (clk),
        .user_rst_n (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic count_loads(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (bus.delay_load) cnt++;
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.ctrl_word = 32'h0;
        bus.sync_in   = 1'b0;
        step(3);
        chk("rst_delay_out", 32'(bus.delay_out), 32'd0);
        chk("rst_load",      32'(bus.delay_load), 32'd0);
        chk("rst_busy",      32'(bus.busy), 32'd0);
        chk("rst_status",    bus.status_word, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Sync-aligned apply after a long wait
        bus.ctrl_word = 32'h8000_0064;
        step(1);
        chk("arm_busy_k", 32'(bus.busy), 32'd0);
        step(1);
        chk("arm_busy_k1", 32'(bus.busy), 32'd1);
        step(50);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        chk("wait_noload", 32'(bus.delay_load), 32'd0);
        bus.sync_in = 1'b1;
        step(1);
        bus.sync_in = 1'b0;
        chk("sync_load", 32'(bus.delay_load), 32'd1);
        chk("sync_delay", 32'(bus.delay_out), 32'd100);
        step(1);
        chk("sync_load_off", 32'(bus.delay_load), 32'd0);
        step(15);
        chk("settle_busy16", 32'(bus.busy), 32'd1);
        step(1);
        chk("settle_busy17", 32'(bus.busy), 32'd0);
        step(1);
        chk("status_cnt1", bus.status_word, 32'h0000_0001);

        // Immediate apply, stray sync during settle
        bus.ctrl_word = 32'h0;
        step(2);
        bus.ctrl_word = 32'hC000_0010;
        step(2);
        chk("imm_load", 32'(bus.delay_load), 32'd1);
        chk("imm_delay", 32'(bus.delay_out), 32'd16);
        bus.sync_in = 1'b1;
        count_loads(3, loads);
        bus.sync_in = 1'b0;
        begin
            int more;
            count_loads(17, more);
            loads += more;
        end
        chk("imm_no_reload", 32'(loads), 32'd0);
        chk("imm_idle", 32'(bus.busy), 32'd0);
        step(1);
        chk("status_cnt2", bus.status_word, 32'h0000_0002);

        // Clamp then clear
        bus.ctrl_word = 32'h0;
        step(2);
        bus.ctrl_word = 32'hC000_0800;
        step(2);
        chk("clamp_delay", 32'(bus.delay_out), 32'd2047);
        step(1);
        chk("clamp_status_load", bus.status_word, 32'h0000_0902);
        step(20);
        chk("clamp_status_idle", bus.status_word, 32'h0000_0103);
        bus.ctrl_word = 32'hE000_0800;
        step(3);
        chk("clear_status", bus.status_word, 32'h0000_0000);

        // Re-arm while waiting for sync
        bus.ctrl_word = 32'h0;
        step(2);
        bus.ctrl_word = 32'h8000_0005;
        step(2);
        chk("rearm_busy", 32'(bus.busy), 32'd1);
        bus.ctrl_word = 32'h0000_0009;
        step(2);
        bus.ctrl_word = 32'h8000_0009;
        step(3);
        chk("rearm_overrun", bus.status_word, 32'h0000_0600);
        bus.sync_in = 1'b1;
        step(1);
        bus.sync_in = 1'b0;
        chk("rearm_load", 32'(bus.delay_load), 32'd1);
        chk("rearm_delay", 32'(bus.delay_out), 32'd5);
        count_loads(20, loads);
        chk("rearm_single", 32'(loads), 32'd0);
        chk("rearm_idle", 32'(bus.busy), 32'd0);

        // Arm bit held high across reset release
        rst_n         = 1'b0;
        bus.ctrl_word = 32'h8000_0007;
        step(2);
        rst_n = 1'b1;
        count_loads(5, loads);
        chk("held_noload", 32'(loads), 32'd0);
        chk("held_busy", 32'(bus.busy), 32'd0);
        chk("held_status", bus.status_word, 32'd0);
        bus.ctrl_word = 32'h4000_0007;
        step(2);
        bus.ctrl_word = 32'hC000_0007;
        step(2);
        chk("held_rearm_load", 32'(bus.delay_load), 32'd1);
        chk("held_rearm_delay", 32'(bus.delay_out), 32'd7);

        // Reset during settle
        step(5);
        chk("settle_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_delay", 32'(bus.delay_out), 32'd0);
        chk("midrst_status", bus.status_word, 32'd0);
        rst_n = 1'b1;

        // apply_count wrap
        for (int i = 0; i < 255; i++) begin
            bus.ctrl_word = 32'h4000_0001;
            step(2);
            bus.ctrl_word = 32'hC000_0001;
            step(19);
        end
        step(1);
        chk("wrap_255", bus.status_word, 32'h0000_00FF);
        bus.ctrl_word = 32'h4000_0001;
        step(2);
        bus.ctrl_word = 32'hC000_0001;
        step(19);
        step(1);
        chk("wrap_0", bus.status_word, 32'h0000_0000);
        chk("wrap_delay", 32'(bus.delay_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
